// File: rtl/approx_mul_seq_ctrl_if.sv
// approx_mul_seq_ctrl_if: handshake bundle for the sequential approximate multiplier.
//   operand side : in_valid, in_ready, x[7:0], y[7:0], abort
//   result side  : out_valid, out_ready, result[15:0], busy
//   master = requester/consumer (drives operands, out_ready, abort); slave = multiplier.
interface approx_mul_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;
    modport master (
        output in_valid, x, y, abort, out_ready,
        input  in_ready, out_valid, result, busy
    );
    modport slave (
        input  in_valid, x, y, abort, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/approx_mul_seq_ctrl.sv
// approx_mul_seq_ctrl: 8x8 approximate multiplier, one partial-product row accumulated per cycle.
//   clk, rst_n (async active-low), bus (approx_mul_seq_ctrl_if.slave).
//   Optional macro ROUND_COMP_EN: accumulator starts from COMP_BIAS instead of 0.
//   ha_array: pairs partial-product rows 2k/2k+1 with approximate half adders.
//     t = even-row bit (sum), b = even & odd overlap (carry, doubles the even bit);
//     an odd-row bit with no even-row partner is dropped.
module ha_array (
    input  logic [7:0]      x,
    input  logic [7:0]      y,
    output logic [3:0][8:0] t,
    output logic [3:0][6:0] b
);
    for (genvar k = 0; k < 4; k++) begin : g_row
        logic [7:0] pe, po;
        assign pe   = x & {8{y[2*k]}};
        assign po   = x & {8{y[2*k+1]}};
        assign t[k] = {po[7], pe};
        assign b[k] = pe[7:1] & po[6:0];
    end
endmodule

module approx_mul_seq_ctrl #(
    parameter logic [15:0] COMP_BIAS = 16'd64
) (
    input logic                 clk,
    input logic                 rst_n,
    approx_mul_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
`ifdef ROUND_COMP_EN
    localparam logic [15:0] ACC_INIT = COMP_BIAS;
`else
    // bias has no effect when compensation is disabled
    localparam logic [15:0] ACC_INIT = COMP_BIAS & 16'h0000;
`endif
    state_t           state_q, state_d;
    logic [7:0]       x_q, y_q;
    logic [15:0]      acc;
    logic [1:0]       row_q;
    logic [3:0][8:0]  t_all;
    logic [3:0][6:0]  b_all;
    logic [15:0]      t_row, b_row, acc_nxt;
    logic [17:0]      sum;

    ha_array u_ha (.x(x_q), .y(y_q), .t(t_all), .b(b_all));

    // single shared accumulation adder; t and b of the selected row enter as a carry-save pair
    always_comb begin
        t_row   = {7'd0, t_all[row_q]} << {row_q, 1'b0};
        b_row   = {8'd0, b_all[row_q], 1'b0} << {row_q, 1'b0};
        sum     = {2'b00, acc} + {2'b00, t_row} + {2'b00, b_row};
        acc_nxt = |sum[17:16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.in_valid ? ACC : IDLE;
            ACC:     state_d = bus.abort ? IDLE : (row_q == 2'd3 ? DONE : ACC);
            DONE:    state_d = (bus.abort || bus.out_ready) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.busy      = state_q != IDLE;
        bus.out_valid = state_q == DONE;
        bus.result    = state_q == DONE ? acc : 16'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            acc   <= '0;
            row_q <= '0;
        end else if (state_q == IDLE && bus.in_valid) begin
            x_q   <= bus.x;
            y_q   <= bus.y;
            acc   <= ACC_INIT;
            row_q <= '0;
        end else if (state_q != IDLE && bus.abort) begin
            acc   <= ACC_INIT;
            row_q <= '0;
        end else if (state_q == ACC) begin
            acc   <= acc_nxt;
            row_q <= row_q + 2'd1;
        end
    end
endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// tb_approx_mul_seq_ctrl: table vectors, corner sequences and a random stream checked via a result scoreboard.
module tb_approx_mul_seq_ctrl;
`ifdef ROUND_COMP_EN
    localparam int BIAS = 64;
`else
    localparam int BIAS = 0;
`endif
    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    approx_mul_seq_ctrl_if bus();

    approx_mul_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // lone odd-row bits are lost; an even-row bit with an odd-row partner counts double
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int s = BIAS;
        for (int k = 0; k < 4; k++) begin
            int r = 0;
            for (int p = 0; p < 8; p++) begin
                bit e = a[p] & b[2*k];
                bit o = (p > 0) ? (a[p-1] & b[2*k+1]) : 1'b0;
                if (e) r += (o ? 2 : 1) << p;
            end
            if (a[7] & b[2*k+1]) r += 256;
            s += r << (2*k);
        end
        return (s > 65535) ? 16'hFFFF : s[15:0];
    endfunction

    always @(negedge clk)
        if (rst_n && bus.out_valid && bus.out_ready && !bus.abort) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_result: got %0d expected none", bus.result);
            end else chk("result", {16'd0, bus.result}, {16'd0, exp_q.pop_front()});
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // accept one operand pair, scramble x/y while busy, return once out_valid is up
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit push, output int lat);
        bus.x = a;
        bus.y = b;
        bus.in_valid = 1'b1;
        if (push) exp_q.push_back(model(a, b));
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.x = 8'($urandom);
            bus.y = 8'($urandom);
            step();
            lat++;
        end
        if (lat >= 20) chk("timeout_out_valid", 32'(bus.out_valid), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab[7];
        int lat;
        logic [15:0] e0;
        bit seen;
        tab[0] = '{8'd1,   8'd1,   16'd1};
        tab[1] = '{8'd2,   8'd3,   16'd2};
        tab[2] = '{8'd0,   8'd0,   16'd0};
        tab[3] = '{8'd255, 8'd255, 16'hFE01};
        tab[4] = '{8'd1,   8'd255, 16'd85};
        tab[5] = '{8'd3,   8'd2,   16'd0};
        tab[6] = '{8'd3,   8'd3,   16'd5};
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_result", 32'(bus.result), 0);
        step();
        rst_n = 1'b1;
        step();
        do_op(8'd1, 8'd1, 1'b1, lat);
        chk("latency", lat, 4);
        step();
        chk("idle_after_handshake", 32'(bus.in_ready), 1);
        foreach (tab[i]) begin
            exp_q.push_back(16'(tab[i].exp + 16'(BIAS)));
            do_op(tab[i].x, tab[i].y, 1'b0, lat);
            step();
        end
        bus.out_ready = 1'b0;
        e0 = 16'(BIAS);
        do_op(8'd0, 8'd0, 1'b1, lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            chk("stall_out_valid", 32'(bus.out_valid), 1);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_result", 32'(bus.result), 32'(e0));
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("idle_after_pulse", 32'(bus.busy), 0);
        bus.x = 8'd1;
        bus.y = 8'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= bus.out_valid;
            step();
        end
        chk("abort_no_out_valid", 32'(seen), 0);
        do_op(8'd1, 8'd1, 1'b1, lat);
        step();
        bus.out_ready = 1'b0;
        do_op(8'd5, 8'd7, 1'b0, lat);
        bus.abort = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_done_busy", 32'(bus.busy), 0);
        chk("abort_done_out_valid", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
        do_op(8'd255, 8'd255, 1'b0, lat);
        chk("pre_reset_out_valid", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_result", 32'(bus.result), 0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 1);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 10000; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'b1, lat);
            step();
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
